// File: rtl/pcs_am_err_pkg.sv
// Shared defaults and helpers for the per-lane alignment-marker BIP error monitor.
package pcs_am_err_pkg;

  localparam int unsigned DefNLanes    = 20;
  localparam int unsigned DefNbBip     = 8;
  localparam int unsigned DefNbCounter = 32;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } win_state_e;

  function automatic int unsigned lane_sel_width(input int unsigned n_lanes);
    return (n_lanes > 1) ? $clog2(n_lanes) : 1;
  endfunction

endpackage

// File: rtl/am_lane_err_cnt.sv
// Single-lane BIP error counter with sticky saturation flag; the high-error
// window FSM is compiled in only when AM_ERR_HI_BER_EN is defined.
module am_lane_err_cnt
  import pcs_am_err_pkg::*;
#(
  parameter int unsigned NbBip        = DefNbBip,
  parameter int unsigned NbCounter    = DefNbCounter,
  parameter int unsigned WindowAm     = 64,
  parameter int unsigned ErrThreshold = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_am_valid,
  input  logic [NbBip-1:0]     i_recived_bip,
  input  logic [NbBip-1:0]     i_calculated_bip,
  input  logic                 i_clear_all,
  input  logic                 i_lane_clear,
  output logic [NbCounter-1:0] o_count,
  output logic                 o_overflow,
  output logic                 o_hi_err
);

  localparam int unsigned IncW = $clog2(NbBip + 1);
  localparam int unsigned SumW = NbCounter + IncW;
  localparam logic [NbCounter-1:0] CountMax = '1;

  logic [IncW-1:0]      inc;
  logic [NbCounter-1:0] count_q, count_d, count_base;
  logic                 ovf_q, ovf_d, ovf_base;
  logic [SumW-1:0]      count_sum;

  assign inc = IncW'($countones(i_recived_bip ^ i_calculated_bip));

  // A read-clear zeroes the base first so a same-cycle increment is kept.
  always_comb begin
    count_base = i_lane_clear ? '0 : count_q;
    ovf_base   = i_lane_clear ? 1'b0 : ovf_q;
    count_sum  = SumW'(count_base) + SumW'(inc);
    count_d    = count_base;
    ovf_d      = ovf_base;
    if (i_clear_all) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (i_enable && i_am_valid) begin
      if (count_sum > SumW'(CountMax)) begin
        count_d = CountMax;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_sum[NbCounter-1:0];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_count    = count_q;
  assign o_overflow = ovf_q;

`ifdef AM_ERR_HI_BER_EN
  localparam int unsigned AmCntW = $clog2(WindowAm + 1);
  localparam int unsigned WinW   = $clog2(ErrThreshold + 1) + 1;
  localparam int unsigned RawW   = ((WinW > IncW) ? WinW : IncW) + 1;
  localparam logic [WinW-1:0] WinMax = '1;

  win_state_e        state_q;
  logic [AmCntW-1:0] am_cnt_q, am_base;
  logic [WinW-1:0]   win_sum_q, win_base, win_next;
  logic [RawW-1:0]   win_raw;
  logic              hi_err_q;

  // In StIdle the window starts from zero, so an AM on the enabling cycle counts.
  always_comb begin
    am_base  = (state_q == StAccum) ? am_cnt_q : '0;
    win_base = (state_q == StAccum) ? win_sum_q : '0;
    win_raw  = RawW'(win_base) + RawW'(inc);
    win_next = (win_raw > RawW'(WinMax)) ? WinMax : win_raw[WinW-1:0];
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      am_cnt_q  <= '0;
      win_sum_q <= '0;
      hi_err_q  <= 1'b0;
    end else if (i_clear_all) begin
      state_q   <= StIdle;
      am_cnt_q  <= '0;
      win_sum_q <= '0;
      hi_err_q  <= 1'b0;
    end else if (!i_enable) begin
      state_q   <= StIdle;
      am_cnt_q  <= '0;
      win_sum_q <= '0;
    end else begin
      state_q   <= StAccum;
      am_cnt_q  <= am_base;
      win_sum_q <= win_base;
      if (i_am_valid) begin
        if (32'(am_base) == WindowAm - 1) begin
          hi_err_q  <= (32'(win_next) > ErrThreshold);
          am_cnt_q  <= '0;
          win_sum_q <= '0;
        end else begin
          am_cnt_q  <= am_base + 1'b1;
          win_sum_q <= win_next;
        end
      end
    end
  end

  assign o_hi_err = hi_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(WindowAm), 32'(ErrThreshold)};
  assign o_hi_err   = 1'b0;
`endif

endmodule

// File: rtl/am_lane_error_monitor.sv
// Multi-lane AM BIP error monitor with registered read port; high-error
// window flags are present only when AM_ERR_HI_BER_EN is defined.
module am_lane_error_monitor
  import pcs_am_err_pkg::*;
#(
  parameter int unsigned N_LANES       = DefNLanes,
  parameter int unsigned NB_BIP        = DefNbBip,
  parameter int unsigned NB_COUNTER    = DefNbCounter,
  parameter int unsigned WINDOW_AM     = 64,
  parameter int unsigned ERR_THRESHOLD = 16
) (
  input  logic                                i_clock,
  input  logic                                i_reset_n,
  input  logic                                i_enable,
  input  logic [N_LANES-1:0]                  i_am_valid,
  input  logic [N_LANES*NB_BIP-1:0]           i_recived_bip,
  input  logic [N_LANES*NB_BIP-1:0]           i_calculated_bip,
  input  logic                                i_clear_all,
  input  logic                                i_rd_req,
  input  logic [lane_sel_width(N_LANES)-1:0]  i_rd_lane,
  input  logic                                i_rd_clear,
  output logic                                o_rd_valid,
  output logic [NB_COUNTER-1:0]               o_rd_count,
  output logic                                o_rd_overflow,
  output logic                                o_rd_err,
  output logic [N_LANES-1:0]                  o_hi_err
);

  logic [NB_COUNTER-1:0] lane_count [N_LANES];
  logic [N_LANES-1:0]    lane_ovf;
  logic [N_LANES-1:0]    lane_clear;
  logic                  rd_in_range;
  logic [NB_COUNTER-1:0] sel_count;
  logic                  sel_ovf;
  logic                  rd_valid_q, rd_ovf_q, rd_err_q;
  logic [NB_COUNTER-1:0] rd_count_q;

  assign rd_in_range = 32'(i_rd_lane) < N_LANES;

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    // Out-of-range lane numbers never match, so a bad read clears nothing.
    assign lane_clear[l] = i_rd_req & i_rd_clear & (32'(i_rd_lane) == l);

    am_lane_err_cnt #(
      .NbBip        (NB_BIP),
      .NbCounter    (NB_COUNTER),
      .WindowAm     (WINDOW_AM),
      .ErrThreshold (ERR_THRESHOLD)
    ) u_lane (
      .i_clock          (i_clock),
      .i_reset_n        (i_reset_n),
      .i_enable         (i_enable),
      .i_am_valid       (i_am_valid[l]),
      .i_recived_bip    (i_recived_bip[l*NB_BIP +: NB_BIP]),
      .i_calculated_bip (i_calculated_bip[l*NB_BIP +: NB_BIP]),
      .i_clear_all      (i_clear_all),
      .i_lane_clear     (lane_clear[l]),
      .o_count          (lane_count[l]),
      .o_overflow       (lane_ovf[l]),
      .o_hi_err         (o_hi_err[l])
    );
  end

  always_comb begin
    sel_count = '0;
    sel_ovf   = 1'b0;
    for (int l = 0; l < N_LANES; l++) begin
      if (32'(i_rd_lane) == 32'(l)) begin
        sel_count = lane_count[l];
        sel_ovf   = lane_ovf[l];
      end
    end
  end

  // Read data is captured from the pre-update state of the request cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      rd_ovf_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= i_rd_req;
      if (i_rd_req) begin
        rd_count_q <= rd_in_range ? sel_count : '0;
        rd_ovf_q   <= rd_in_range & sel_ovf;
        rd_err_q   <= ~rd_in_range;
      end
    end
  end

  assign o_rd_valid    = rd_valid_q;
  assign o_rd_count    = rd_count_q;
  assign o_rd_overflow = rd_ovf_q;
  assign o_rd_err      = rd_err_q;

endmodule

// File: doc/am_lane_error_monitor.md
AM_LANE_ERROR_MONITOR -- requirements
Module: am_lane_error_monitor

Interface
REQ-001 SHALL have parameter N_LANES, default 20, number of PCS lanes monitored.
REQ-002 SHALL have parameter NB_BIP, default 8, BIP width per lane.
REQ-003 SHALL have parameter NB_COUNTER, default 32, per-lane error counter width.
REQ-004 SHALL have parameter WINDOW_AM, default 64, alignment markers per high-error window.
REQ-005 SHALL have parameter ERR_THRESHOLD, default 16, window error count above which a lane is flagged.
REQ-006 SHALL have ports (name  direction  width  meaning):
 i_clock  in  1  single clock, rising edge
 i_reset_n  in  1  asynchronous active-low reset
 i_enable  in  1  global monitor enable
 i_am_valid  in  N_LANES  per-lane AM matched this cycle
 i_recived_bip  in  N_LANES*NB_BIP  received BIP, lane l at bits [l*NB_BIP +: NB_BIP]
 i_calculated_bip  in  N_LANES*NB_BIP  locally computed BIP, same packing
 i_clear_all  in  1  synchronous clear of all counters and sticky flags
 i_rd_req  in  1  read request
 i_rd_lane  in  $clog2(N_LANES)  lane to read
 i_rd_clear  in  1  clear addressed lane on read
 o_rd_valid  out  1  read data valid
 o_rd_count  out  NB_COUNTER  addressed lane count
 o_rd_overflow  out  1  addressed lane sticky saturation flag
 o_rd_err  out  1  i_rd_lane out of range
 o_hi_err  out  N_LANES  per-lane high-error flag

Function
REQ-007 Per-lane error increment SHALL be the popcount of (received XOR calculated), range 0..NB_BIP.
REQ-008 Lane counter SHALL update one cycle after a cycle with i_enable=1 and i_am_valid[l]=1; other lanes are unaffected.
REQ-009 Counter SHALL saturate at 2^NB_COUNTER-1; any update that would exceed it SHALL load the maximum and set the lane's sticky overflow flag; no wrap-around.
REQ-010 i_clear_all SHALL zero all counters, overflow flags, window state and o_hi_err; it SHALL win over a simultaneous update or read-clear.
REQ-011 A read SHALL return, one cycle after i_rd_req, the lane count and overflow flag as they were before that cycle's update; o_rd_valid SHALL pulse for exactly one cycle.
REQ-012 i_rd_clear with i_rd_req SHALL zero the lane counter and overflow flag; an update in the same cycle SHALL load only that cycle's increment, so no error is lost.
REQ-013 If i_rd_lane >= N_LANES, the block SHALL return o_rd_count=0, o_rd_overflow=0 and o_rd_err=1 with o_rd_valid, and no state SHALL change.
REQ-014 Per-lane window FSM states SHALL be:
 - IDLE: entered on reset or i_enable=0; window counters cleared; o_hi_err held.
 - ACCUM: entered from IDLE when i_enable=1.
REQ-015 In ACCUM, each valid AM SHALL increment an AM count and add its increment to a window error sum that saturates at its width.
REQ-016 On the WINDOW_AM-th AM, o_hi_err[l] SHALL register (window sum including that AM > ERR_THRESHOLD) on the next cycle; the window SHALL then restart with zero.
REQ-017 o_hi_err SHALL change only at window end or on clear/reset.

Reset
REQ-018 Asserting i_reset_n low SHALL asynchronously zero all counters, overflow flags, window state, o_hi_err, o_rd_valid, o_rd_count, o_rd_overflow and o_rd_err, and put every lane FSM in IDLE.
REQ-019 Reset asserted mid-window SHALL discard the partial window; release SHALL be synchronous to i_clock.

Configuration
REQ-020 Macro AM_ERR_HI_BER_EN defined SHALL compile in the window FSM and o_hi_err logic (REQ-014..017).
REQ-021 With AM_ERR_HI_BER_EN undefined, o_hi_err SHALL be tied to 0, the window logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-022 Package pcs_am_err_pkg SHALL hold the default lane count, BIP width, counter width and the lane-select width function.
REQ-023 One sub-module, am_lane_err_cnt, SHALL implement the single-lane popcount, saturating counter, sticky flag and window FSM; the top SHALL generate N_LANES instances plus the read mux.

Verification
REQ-024 Lane 3: rx=8'hFF, calc=8'h00, one AM -> read lane 3 returns 8 one cycle after the request; all other lanes read 0.
REQ-025 NB_COUNTER=4, lane 0 count 14: AM with 3 bit errors -> count 15, overflow=1; a further AM keeps count 15.
REQ-026 Lane 5 count 10: i_rd_req+i_rd_clear with a same-cycle AM of 2 errors -> read returns 10; the next read returns 2.
REQ-027 WINDOW_AM=4, ERR_THRESHOLD=16: four AMs of 5 errors (sum 20) -> o_hi_err[l]=1; the next window of 4x0 errors -> o_hi_err[l]=0.
REQ-028 i_rd_lane=25 with N_LANES=20 -> o_rd_err=1, o_rd_count=0, no counter change.
REQ-029 i_reset_n low after 2 window AMs, then release -> all outputs 0; a fresh window requires WINDOW_AM new AMs.
